// File: rtl/mem_oc_pkg.sv
// Shared types and constants for the memory-unit operand collector.
package mem_oc_pkg;
  localparam int WARP_W  = 3;
  localparam int SCB_W   = 2;
  localparam int DATA_W  = 256;
  localparam int PAM_W   = 8;
  localparam int RADDR_W = 5;
  localparam int OFF_W   = 16;

  localparam logic OP_RS = 1'b0;
  localparam logic OP_RT = 1'b1;

  typedef struct packed {
    logic               vld;
    logic               rd;
    logic               wr;
    logic               sgb;
    logic [PAM_W-1:0]   pam;
    logic [WARP_W-1:0]  warp;
    logic [SCB_W-1:0]   scb;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [RADDR_W-1:0] reg_addr;
    logic [OFF_W-1:0]   off;
    logic               rs_req;
    logic               rs_ok;
    logic               rt_req;
    logic               rt_ok;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
  } entry_t;

  // One read in flight; the entry index is held alongside since its width follows DEPTH.
  typedef struct packed {
    logic vld;
    logic sel;
  } pend_t;
endpackage

// File: rtl/mem_oc_dispatch_read_arb.sv
// Oldest-first operand-read arbiter: scans from the head, rs before rt within an entry.
module mem_oc_read_arb
  import mem_oc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [PW-1:0]    i_head,
  input  logic [DEPTH-1:0] i_need_rs,
  input  logic [DEPTH-1:0] i_need_rt,
  output logic             o_gnt_vld,
  output logic [PW-1:0]    o_gnt_idx,
  output logic             o_gnt_sel
);
  logic [PW-1:0] w_idx;

  // Scan youngest to oldest so the oldest requester overwrites the result last.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    o_gnt_sel = OP_RS;
    w_idx     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_idx = i_head + PW'(k);
      if (i_need_rs[w_idx] || i_need_rt[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
        o_gnt_sel = i_need_rs[w_idx] ? OP_RS : OP_RT;
      end
    end
  end
endmodule

// File: rtl/mem_oc_dispatch.sv
// In-order operand collector feeding the memory unit through one RF read port.
module mem_oc_dispatch
  import mem_oc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Instr_valid_IB_OC,
  input  logic                MemRead_IB_OC,
  input  logic                MemWrite_IB_OC,
  input  logic                shared_global_bar_IB_OC,
  input  logic                rt_used_IB_OC,
  input  logic [PAM_W-1:0]    PAM_IB_OC,
  input  logic [WARP_W-1:0]   warp_ID_IB_OC,
  input  logic [SCB_W-1:0]    scb_ID_IB_OC,
  input  logic [RADDR_W-1:0]  rs_addr_IB_OC,
  input  logic [RADDR_W-1:0]  rt_addr_IB_OC,
  input  logic [RADDR_W-1:0]  reg_addr_IB_OC,
  input  logic [OFF_W-1:0]    offset_IB_OC,
  output logic                full_OC_IB,
  output logic                rf_rd_valid_OC_RF,
  output logic [WARP_W-1:0]   rf_rd_warp_OC_RF,
  output logic [RADDR_W-1:0]  rf_rd_addr_OC_RF,
  input  logic [DATA_W-1:0]   rf_rd_data_RF_OC,
  input  logic                mem_stall_MEM_OC,
  output logic                Instr_valid_OC_MEM,
  output logic                MemRead_OC_MEM,
  output logic                MemWrite_OC_MEM,
  output logic                shared_global_bar_OC_MEM,
  output logic [PAM_W-1:0]    PAM_OC_MEM,
  output logic [WARP_W-1:0]   warp_ID_OC_MEM,
  output logic [SCB_W-1:0]    scb_ID_o_OC_MEM,
  output logic [DATA_W-1:0]   rs_data_OC_MEM,
  output logic [DATA_W-1:0]   rt_data_OC_MEM,
  output logic [OFF_W-1:0]    offset_OC_MEM,
  output logic [RADDR_W-1:0]  reg_addr_OC_MEM
);
  localparam int PW = $clog2(DEPTH);

  entry_t         r_ent [DEPTH];
  pend_t          r_pend;
  logic [PW-1:0]  r_pend_idx;
  logic [PW-1:0]  r_head, r_tail;
  logic [PW:0]    r_cnt;

  logic           r_ovld, r_ord, r_owr, r_osgb;
  logic [PAM_W-1:0]   r_opam;
  logic [WARP_W-1:0]  r_owarp;
  logic [SCB_W-1:0]   r_oscb;
  logic [DATA_W-1:0]  r_ors, r_ort;
  logic [OFF_W-1:0]   r_ooff;
  logic [RADDR_W-1:0] r_oreg;

  logic [DEPTH-1:0] w_need_rs, w_need_rt;
  logic             w_gnt_vld, w_gnt_sel;
  logic [PW-1:0]    w_gnt_idx;
  entry_t           w_gnt_ent, w_head_ent, w_new;
  logic             w_alloc, w_disp;

  assign full_OC_IB = (r_cnt == (PW+1)'(DEPTH));
  assign w_alloc    = Instr_valid_IB_OC & ~full_OC_IB;
  assign w_head_ent = r_ent[r_head];
  assign w_disp     = w_head_ent.vld & w_head_ent.rs_ok & w_head_ent.rt_ok & ~mem_stall_MEM_OC;
  assign w_gnt_ent  = r_ent[w_gnt_idx];

  always_comb begin
    w_need_rs = '0;
    w_need_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_need_rs[i] = r_ent[i].vld & ~r_ent[i].rs_req;
      w_need_rt[i] = r_ent[i].vld & ~r_ent[i].rt_req & ~r_ent[i].rt_ok;
    end
  end

  mem_oc_read_arb #(.DEPTH(DEPTH)) u_arb (
    .i_head    (r_head),
    .i_need_rs (w_need_rs),
    .i_need_rt (w_need_rt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_sel (w_gnt_sel)
  );

  assign rf_rd_valid_OC_RF = w_gnt_vld;
  assign rf_rd_warp_OC_RF  = w_gnt_vld ? w_gnt_ent.warp : '0;
  assign rf_rd_addr_OC_RF  = !w_gnt_vld ? '0 :
                             (w_gnt_sel == OP_RS) ? w_gnt_ent.rs_addr : w_gnt_ent.rt_addr;

  // A load never needs rt, so its rt slot is marked collected at allocation.
  always_comb begin
    w_new          = '0;
    w_new.vld      = 1'b1;
    w_new.rd       = MemRead_IB_OC;
    w_new.wr       = MemWrite_IB_OC;
    w_new.sgb      = shared_global_bar_IB_OC;
    w_new.pam      = PAM_IB_OC;
    w_new.warp     = warp_ID_IB_OC;
    w_new.scb      = scb_ID_IB_OC;
    w_new.rs_addr  = rs_addr_IB_OC;
    w_new.rt_addr  = rt_addr_IB_OC;
    w_new.reg_addr = reg_addr_IB_OC;
    w_new.off      = offset_IB_OC;
    w_new.rt_ok    = ~rt_used_IB_OC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_pend     <= '0;
      r_pend_idx <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_ovld     <= 1'b0;
      r_ord      <= 1'b0;
      r_owr      <= 1'b0;
      r_osgb     <= 1'b0;
      r_opam     <= '0;
      r_owarp    <= '0;
      r_oscb     <= '0;
      r_ors      <= '0;
      r_ort      <= '0;
      r_ooff     <= '0;
      r_oreg     <= '0;
    end else begin
      if (r_pend.vld) begin
        if (r_pend.sel == OP_RS) begin
          r_ent[r_pend_idx].rs_data <= rf_rd_data_RF_OC;
          r_ent[r_pend_idx].rs_ok   <= 1'b1;
        end else begin
          r_ent[r_pend_idx].rt_data <= rf_rd_data_RF_OC;
          r_ent[r_pend_idx].rt_ok   <= 1'b1;
        end
      end
      r_pend.vld <= w_gnt_vld;
      r_pend.sel <= w_gnt_sel;
      r_pend_idx <= w_gnt_idx;
      if (w_gnt_vld) begin
        if (w_gnt_sel == OP_RS) r_ent[w_gnt_idx].rs_req <= 1'b1;
        else                    r_ent[w_gnt_idx].rt_req <= 1'b1;
      end

      r_ovld <= w_disp;
      if (w_disp) begin
        r_ord            <= w_head_ent.rd;
        r_owr            <= w_head_ent.wr;
        r_osgb           <= w_head_ent.sgb;
        r_opam           <= w_head_ent.pam;
        r_owarp          <= w_head_ent.warp;
        r_oscb           <= w_head_ent.scb;
        r_ors            <= w_head_ent.rs_data;
        r_ort            <= w_head_ent.rt_data;
        r_ooff           <= w_head_ent.off;
        r_oreg           <= w_head_ent.reg_addr;
        r_ent[r_head].vld <= 1'b0;
        r_head           <= r_head + 1'b1;
      end

      if (w_alloc) begin
        r_ent[r_tail] <= w_new;
        r_tail        <= r_tail + 1'b1;
      end

      case ({w_alloc, w_disp})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign Instr_valid_OC_MEM       = r_ovld;
  assign MemRead_OC_MEM           = r_ord;
  assign MemWrite_OC_MEM          = r_owr;
  assign shared_global_bar_OC_MEM = r_osgb;
  assign PAM_OC_MEM               = r_opam;
  assign warp_ID_OC_MEM           = r_owarp;
  assign scb_ID_o_OC_MEM          = r_oscb;
  assign rs_data_OC_MEM           = r_ors;
  assign rt_data_OC_MEM           = r_ort;
  assign offset_OC_MEM            = r_ooff;
  assign reg_addr_OC_MEM          = r_oreg;
endmodule

// File: tb/tb_mem_oc_dispatch.sv
// Directed bench for mem_oc_dispatch with an RF model and dispatch/read monitors.
module tb_mem_oc_dispatch;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_vld = 1'b0, i_rd = 1'b0, i_wr = 1'b0, i_sgb = 1'b0, i_rtu = 1'b0;
  logic [7:0]   i_pam = '0;
  logic [2:0]   i_warp = '0;
  logic [1:0]   i_scb = '0;
  logic [4:0]   i_rs = '0, i_rt = '0, i_reg = '0;
  logic [15:0]  i_off = '0;
  logic         full, rf_vld;
  logic [2:0]   rf_warp;
  logic [4:0]   rf_addr;
  logic [255:0] rf_data = '0;
  logic         stall = 1'b0;
  logic         o_vld, o_rd, o_wr, o_sgb;
  logic [7:0]   o_pam;
  logic [2:0]   o_warp;
  logic [1:0]   o_scb;
  logic [255:0] o_rs, o_rt;
  logic [15:0]  o_off;
  logic [4:0]   o_reg;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic         rd, wr;
    logic [7:0]   pam;
    logic [2:0]   warp;
    logic [1:0]   scb;
    logic [4:0]   reg_a;
    logic [15:0]  off;
    logic [255:0] rs, rt;
  } dsp_t;
  dsp_t       dsp_q[$];
  logic [7:0] rd_q[$];

  mem_oc_dispatch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .Instr_valid_IB_OC(i_vld), .MemRead_IB_OC(i_rd), .MemWrite_IB_OC(i_wr),
    .shared_global_bar_IB_OC(i_sgb), .rt_used_IB_OC(i_rtu), .PAM_IB_OC(i_pam),
    .warp_ID_IB_OC(i_warp), .scb_ID_IB_OC(i_scb), .rs_addr_IB_OC(i_rs),
    .rt_addr_IB_OC(i_rt), .reg_addr_IB_OC(i_reg), .offset_IB_OC(i_off),
    .full_OC_IB(full), .rf_rd_valid_OC_RF(rf_vld), .rf_rd_warp_OC_RF(rf_warp),
    .rf_rd_addr_OC_RF(rf_addr), .rf_rd_data_RF_OC(rf_data), .mem_stall_MEM_OC(stall),
    .Instr_valid_OC_MEM(o_vld), .MemRead_OC_MEM(o_rd), .MemWrite_OC_MEM(o_wr),
    .shared_global_bar_OC_MEM(o_sgb), .PAM_OC_MEM(o_pam), .warp_ID_OC_MEM(o_warp),
    .scb_ID_o_OC_MEM(o_scb), .rs_data_OC_MEM(o_rs), .rt_data_OC_MEM(o_rt),
    .offset_OC_MEM(o_off), .reg_addr_OC_MEM(o_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rf_val(input logic [2:0] w, input logic [4:0] a);
    if (a == 5'd2) return {32{8'h60}};
    if (a == 5'd4) return {256{1'b1}};
    return {32{w, a}};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_data <= rf_vld ? rf_val(rf_warp, rf_addr) : 256'd0;
  end

  always @(negedge clk) begin
    if (!rst && o_vld)
      dsp_q.push_back('{cyc, o_rd, o_wr, o_pam, o_warp, o_scb, o_reg, o_off, o_rs, o_rt});
    if (!rst && rf_vld) rd_q.push_back({rf_warp, rf_addr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [7:0] pam, input logic [2:0] w,
                       input logic [1:0] s, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rg, input logic [15:0] off);
    i_vld = 1'b1; i_rd = ~st; i_wr = st; i_sgb = 1'b0; i_rtu = st;
    i_pam = pam; i_warp = w; i_scb = s; i_rs = rs; i_rt = rt; i_reg = rg; i_off = off;
  endtask

  task automatic wait_dsp(input int n, input int lim);
    for (int k = 0; k < lim && dsp_q.size() < n; k++) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %b want 0", o_vld); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full); end
    n_vec++; if (rf_vld !== 1'b0) begin n_err++; $display("FAIL rst_rfvld got %b want 0", rf_vld); end
    n_vec++; if (o_rs !== 256'd0) begin n_err++; $display("FAIL rst_rs got %h want 0", o_rs); end
    rst = 1'b0;
    repeat (2) tick();
    n_vec++; if (o_vld !== 1'b0 || rf_vld !== 1'b0) begin
      n_err++; $display("FAIL rst_idle got vld=%b rf=%b want 0/0", o_vld, rf_vld);
    end
  endtask

  task automatic test_store();
    int t0;
    dsp_q.delete(); rd_q.delete();
    drive(1'b1, 8'hFF, 3'd1, 2'd1, 5'd2, 5'd4, 5'd6, 16'h1234);
    t0 = cyc;
    tick();
    i_vld = 1'b0;
    wait_dsp(1, 20);
    repeat (5) tick();
    n_vec++; if (rd_q.size() !== 2) begin n_err++; $display("FAIL st_nreads got %0d want 2", rd_q.size()); end
    if (rd_q.size() >= 2) begin
      n_vec++; if (rd_q[0] !== {3'd1, 5'd2}) begin n_err++; $display("FAIL st_rd0 got %h want %h", rd_q[0], {3'd1, 5'd2}); end
      n_vec++; if (rd_q[1] !== {3'd1, 5'd4}) begin n_err++; $display("FAIL st_rd1 got %h want %h", rd_q[1], {3'd1, 5'd4}); end
    end
    n_vec++; if (dsp_q.size() !== 1) begin n_err++; $display("FAIL st_ndsp got %0d want 1", dsp_q.size()); end
    if (dsp_q.size() >= 1) begin
      n_vec++; if (dsp_q[0].cyc - t0 !== 5) begin n_err++; $display("FAIL st_lat got %0d want 5", dsp_q[0].cyc - t0); end
      n_vec++; if (dsp_q[0].wr !== 1'b1 || dsp_q[0].rd !== 1'b0) begin
        n_err++; $display("FAIL st_flags got wr=%b rd=%b want 1/0", dsp_q[0].wr, dsp_q[0].rd);
      end
      n_vec++; if (dsp_q[0].rs !== {32{8'h60}}) begin n_err++; $display("FAIL st_rs got %h want 6060..", dsp_q[0].rs); end
      n_vec++; if (dsp_q[0].rt !== {256{1'b1}}) begin n_err++; $display("FAIL st_rt got %h want ffff..", dsp_q[0].rt); end
      n_vec++; if (dsp_q[0].pam !== 8'hFF || dsp_q[0].warp !== 3'd1 || dsp_q[0].scb !== 2'd1) begin
        n_err++; $display("FAIL st_ids got pam=%h w=%0d s=%0d want ff/1/1", dsp_q[0].pam, dsp_q[0].warp, dsp_q[0].scb);
      end
      n_vec++; if (dsp_q[0].off !== 16'h1234 || dsp_q[0].reg_a !== 5'd6) begin
        n_err++; $display("FAIL st_off got off=%h reg=%0d want 1234/6", dsp_q[0].off, dsp_q[0].reg_a);
      end
    end
    n_vec++; if (o_vld !== 1'b0 || o_rs !== {32{8'h60}}) begin
      n_err++; $display("FAIL st_hold got vld=%b rs=%h want 0/6060..", o_vld, o_rs);
    end
  endtask

  task automatic test_load();
    int t0;
    dsp_q.delete(); rd_q.delete();
    drive(1'b0, 8'hF0, 3'd2, 2'd3, 5'd7, 5'd9, 5'd3, 16'h0040);
    t0 = cyc;
    tick();
    i_vld = 1'b0;
    wait_dsp(1, 20);
    repeat (4) tick();
    n_vec++; if (rd_q.size() !== 1) begin n_err++; $display("FAIL ld_nreads got %0d want 1", rd_q.size()); end
    n_vec++; if (dsp_q.size() !== 1) begin n_err++; $display("FAIL ld_ndsp got %0d want 1", dsp_q.size()); end
    if (dsp_q.size() >= 1) begin
      n_vec++; if (dsp_q[0].cyc - t0 !== 4) begin n_err++; $display("FAIL ld_lat got %0d want 4", dsp_q[0].cyc - t0); end
      n_vec++; if (dsp_q[0].reg_a !== 5'd3 || dsp_q[0].pam !== 8'hF0 || dsp_q[0].rd !== 1'b1) begin
        n_err++; $display("FAIL ld_fields got reg=%0d pam=%h rd=%b want 3/f0/1", dsp_q[0].reg_a, dsp_q[0].pam, dsp_q[0].rd);
      end
      n_vec++; if (dsp_q[0].rt !== 256'd0) begin n_err++; $display("FAIL ld_rt got %h want 0", dsp_q[0].rt); end
      n_vec++; if (dsp_q[0].rs !== {32{8'h47}}) begin n_err++; $display("FAIL ld_rs got %h want 4747..", dsp_q[0].rs); end
    end
  endtask

  task automatic test_fill();
    dsp_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h0F, 3'(i), 2'd0, 5'(i + 8), 5'd0, 5'(i), 16'(i));
      tick();
      n_vec++; if (full !== (i >= 3)) begin n_err++; $display("FAIL fill_full%0d got %b want %b", i, full, i >= 3); end
    end
    i_vld = 1'b0;
    repeat (4) tick();
    n_vec++; if (dsp_q.size() !== 0) begin n_err++; $display("FAIL fill_stalled got %0d want 0", dsp_q.size()); end
    stall = 1'b0;
    wait_dsp(4, 20);
    repeat (5) tick();
    n_vec++; if (dsp_q.size() !== 4) begin n_err++; $display("FAIL fill_ndsp got %0d want 4", dsp_q.size()); end
    for (int i = 0; i < 4 && i < dsp_q.size(); i++) begin
      n_vec++; if (dsp_q[i].warp !== 3'(i)) begin n_err++; $display("FAIL fill_ord%0d got %0d want %0d", i, dsp_q[i].warp, i); end
    end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_drain got %b want 0", full); end
  endtask

  task automatic test_back_to_back();
    int t0;
    dsp_q.delete();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h01, 3'(i), 2'(i), 5'(i), 5'd0, 5'(i + 16), 16'(i));
      n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL b2b_full%0d got %b want 0", i, full); end
      tick();
    end
    i_vld = 1'b0;
    wait_dsp(10, 30);
    n_vec++; if (dsp_q.size() !== 10) begin n_err++; $display("FAIL b2b_ndsp got %0d want 10", dsp_q.size()); end
    for (int i = 0; i < 10 && i < dsp_q.size(); i++) begin
      n_vec++; if (dsp_q[i].reg_a !== 5'(i + 16)) begin
        n_err++; $display("FAIL b2b_ord%0d got %0d want %0d", i, dsp_q[i].reg_a, i + 16);
      end
      n_vec++; if (dsp_q[i].cyc - t0 !== 4 + i) begin
        n_err++; $display("FAIL b2b_cyc%0d got %0d want %0d", i, dsp_q[i].cyc - t0, 4 + i);
      end
    end
  endtask

  task automatic test_stall_hold();
    int t1;
    dsp_q.delete();
    stall = 1'b1;
    drive(1'b0, 8'hAA, 3'd5, 2'd2, 5'd1, 5'd0, 5'd9, 16'hBEEF);
    tick();
    i_vld = 1'b0;
    repeat (5) tick();
    n_vec++; if (dsp_q.size() !== 0) begin n_err++; $display("FAIL sh_early got %0d want 0", dsp_q.size()); end
    stall = 1'b0;
    t1 = cyc;
    wait_dsp(1, 10);
    n_vec++; if (dsp_q.size() !== 1) begin n_err++; $display("FAIL sh_ndsp got %0d want 1", dsp_q.size()); end
    if (dsp_q.size() >= 1) begin
      n_vec++; if (dsp_q[0].cyc - t1 !== 1) begin n_err++; $display("FAIL sh_lat got %0d want 1", dsp_q[0].cyc - t1); end
      n_vec++; if (dsp_q[0].off !== 16'hBEEF) begin n_err++; $display("FAIL sh_off got %h want beef", dsp_q[0].off); end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h33, 3'(i), 2'd0, 5'(i), 5'(i + 4), 5'd1, 16'h00FF);
      tick();
    end
    i_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++; if (o_rs !== 256'd0 || o_rt !== 256'd0) begin n_err++; $display("FAIL rm_data got rs=%h rt=%h want 0", o_rs, o_rt); end
    n_vec++; if (o_off !== 16'd0 || o_pam !== 8'd0 || o_reg !== 5'd0 || o_warp !== 3'd0) begin
      n_err++; $display("FAIL rm_fields got off=%h pam=%h reg=%0d w=%0d want 0", o_off, o_pam, o_reg, o_warp);
    end
    n_vec++; if (full !== 1'b0 || rf_vld !== 1'b0 || o_vld !== 1'b0) begin
      n_err++; $display("FAIL rm_ctl got full=%b rf=%b vld=%b want 0", full, rf_vld, o_vld);
    end
    tick(); tick();
    rst = 1'b0;
    stall = 1'b0;
    dsp_q.delete(); rd_q.delete();
    repeat (15) tick();
    n_vec++; if (dsp_q.size() !== 0 || rd_q.size() !== 0) begin
      n_err++; $display("FAIL rm_quiet got dsp=%0d rd=%0d want 0/0", dsp_q.size(), rd_q.size());
    end
    drive(1'b0, 8'h11, 3'd6, 2'd1, 5'd3, 5'd0, 5'd12, 16'h0007);
    t0 = cyc;
    tick();
    i_vld = 1'b0;
    wait_dsp(1, 20);
    n_vec++; if (dsp_q.size() !== 1) begin n_err++; $display("FAIL rm_new got %0d want 1", dsp_q.size()); end
    if (dsp_q.size() >= 1) begin
      n_vec++; if (dsp_q[0].cyc - t0 !== 4 || dsp_q[0].rs !== {32{8'hC3}}) begin
        n_err++; $display("FAIL rm_newdsp got lat=%0d rs=%h want 4/c3c3..", dsp_q[0].cyc - t0, dsp_q[0].rs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fill();
    test_back_to_back();
    test_stall_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
